// File: rtl/gpu_pkg.sv
// gpu_pkg: shared types for the GPU command scheduler and the fill/blit engine.
// Rev 1.0
`default_nettype none

package gpu_pkg;

    localparam int X_W = 9;
    localparam int Y_W = 8;

    localparam logic OP_FILL = 1'b0;
    localparam logic OP_BLIT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    typedef struct packed {
        logic           op;
        logic [X_W-1:0] x1;
        logic [Y_W-1:0] y1;
        logic [X_W-1:0] x2;
        logic [Y_W-1:0] y2;
        logic           fill_value;
        logic [X_W-1:0] blit_w;
        logic [Y_W-1:0] blit_h;
    } cmd_t;

endpackage

`default_nettype wire

// File: rtl/gpu_cmd_fifo.sv
// gpu_cmd_fifo: synchronous FIFO of command structs; head is valid while non-empty.
// Rev 1.0
`default_nettype none

module gpu_cmd_fifo
    import gpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  cmd_t                     din_i,
    input  logic                     pop_i,
    output cmd_t                     head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          w_push;
    logic          w_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: only entries below count_q are ever observed.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/gpu_cmd_scheduler.sv
// gpu_cmd_scheduler: queues host fill/blit commands and issues them one at a time to the engine.
// Rev 1.0
`default_nettype none

module gpu_cmd_scheduler
    import gpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_op,
    input  logic [X_W-1:0]           cmd_x1,
    input  logic [X_W-1:0]           cmd_x2,
    input  logic [Y_W-1:0]           cmd_y1,
    input  logic [Y_W-1:0]           cmd_y2,
    input  logic                     cmd_fill_value,
    input  logic [X_W-1:0]           cmd_blit_w,
    input  logic [Y_W-1:0]           cmd_blit_h,
    output logic [X_W-1:0]           eng_x1,
    output logic [X_W-1:0]           eng_x2,
    output logic [Y_W-1:0]           eng_y1,
    output logic [Y_W-1:0]           eng_y2,
    output logic                     eng_fill_value,
    output logic [X_W-1:0]           eng_blit_w,
    output logic [Y_W-1:0]           eng_blit_h,
    output logic                     eng_start_fill,
    output logic                     eng_start_blit,
    input  logic                     eng_busy,
    input  logic                     eng_error,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     idle,
    output logic                     err_sticky,
    input  logic                     err_clear,
    output logic [CNT_W-1:0]         done_count
);

    cmd_t             w_cmd;
    cmd_t             w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_issue;
    logic             w_pop;
    logic             w_done;
    logic             w_rej;

    state_t           state_q, state_d;
    cmd_t             eng_q, eng_d;
    logic             start_fill_q, start_fill_d;
    logic             start_blit_q, start_blit_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] done_q, done_d;

    assign w_cmd = '{op: cmd_op, x1: cmd_x1, y1: cmd_y1, x2: cmd_x2, y2: cmd_y2,
                     fill_value: cmd_fill_value, blit_w: cmd_blit_w, blit_h: cmd_blit_h};

    assign cmd_ready = ~w_full;

    gpu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid & cmd_ready),
        .din_i   (w_cmd),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (queue_count)
    );

    // Waiting on eng_busy in IDLE also covers an engine left running across a reset.
    assign w_issue = (state_q == ST_IDLE) & ~w_empty & ~eng_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_issue) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_ACK;
            ST_ACK:   state_d = eng_busy ? ST_RUN : ST_IDLE;
            ST_RUN:   if (!eng_busy) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        eng_d        = eng_q;
        start_fill_d = 1'b0;
        start_blit_d = 1'b0;
        w_pop        = 1'b0;
        w_done       = 1'b0;
        w_rej        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_issue) begin
                    eng_d        = w_head;
                    start_fill_d = (w_head.op == OP_FILL);
                    start_blit_d = (w_head.op == OP_BLIT);
                end
            end
            ST_ACK: begin
                if (!eng_busy) begin
                    w_pop  = 1'b1;
                    w_rej  = eng_error;
                    w_done = ~eng_error;
                end
            end
            ST_RUN: begin
                if (!eng_busy) begin
                    w_pop  = 1'b1;
                    w_done = 1'b1;
                end
            end
            default: ;
        endcase
        err_d  = w_rej | (err_q & ~err_clear);
        done_d = done_q + CNT_W'(w_done);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_q        <= '0;
            start_fill_q <= 1'b0;
            start_blit_q <= 1'b0;
            err_q        <= 1'b0;
            done_q       <= '0;
        end else begin
            eng_q        <= eng_d;
            start_fill_q <= start_fill_d;
            start_blit_q <= start_blit_d;
            err_q        <= err_d;
            done_q       <= done_d;
        end
    end

    assign eng_x1         = eng_q.x1;
    assign eng_x2         = eng_q.x2;
    assign eng_y1         = eng_q.y1;
    assign eng_y2         = eng_q.y2;
    assign eng_fill_value = eng_q.fill_value;
    assign eng_blit_w     = eng_q.blit_w;
    assign eng_blit_h     = eng_q.blit_h;
    assign eng_start_fill = start_fill_q;
    assign eng_start_blit = start_blit_q;
    assign err_sticky     = err_q;
    assign done_count     = done_q;
    assign idle           = w_empty & (state_q == ST_IDLE) & ~eng_busy;

endmodule

`default_nettype wire

// File: tb/tb_gpu_cmd_scheduler.sv
// tb_gpu_cmd_scheduler: scoreboard bench with a behavioural fill/blit engine model.
// Rev 1.0
`default_nettype none

module tb_gpu_cmd_scheduler;
    import gpu_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_op = 1'b0;
    logic [X_W-1:0]   cmd_x1 = '0, cmd_x2 = '0, cmd_blit_w = '0;
    logic [Y_W-1:0]   cmd_y1 = '0, cmd_y2 = '0, cmd_blit_h = '0;
    logic             cmd_fill_value = 1'b0;
    logic [X_W-1:0]   eng_x1, eng_x2, eng_blit_w;
    logic [Y_W-1:0]   eng_y1, eng_y2, eng_blit_h;
    logic             eng_fill_value, eng_start_fill, eng_start_blit;
    logic             eng_busy;
    logic             eng_error = 1'b0;
    logic [$clog2(DEPTH):0] queue_count;
    logic             idle, err_sticky;
    logic             err_clear = 1'b0;
    logic [CNT_W-1:0] done_count;

    gpu_cmd_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x1(cmd_x1), .cmd_x2(cmd_x2), .cmd_y1(cmd_y1), .cmd_y2(cmd_y2),
        .cmd_fill_value(cmd_fill_value), .cmd_blit_w(cmd_blit_w), .cmd_blit_h(cmd_blit_h),
        .eng_x1(eng_x1), .eng_x2(eng_x2), .eng_y1(eng_y1), .eng_y2(eng_y2),
        .eng_fill_value(eng_fill_value), .eng_blit_w(eng_blit_w), .eng_blit_h(eng_blit_h),
        .eng_start_fill(eng_start_fill), .eng_start_blit(eng_start_blit),
        .eng_busy(eng_busy), .eng_error(eng_error),
        .queue_count(queue_count), .idle(idle),
        .err_sticky(err_sticky), .err_clear(err_clear), .done_count(done_count)
    );

    // Engine model: rejects reversed rectangles, otherwise busy for eng_len cycles.
    int   eng_len   = 6;
    int   busy_cnt  = 0;
    logic hold_busy = 1'b0;

    always @(posedge clk) begin
        if (eng_start_fill || eng_start_blit) begin
            if (eng_x1 > eng_x2 || eng_y1 > eng_y2) begin
                eng_error <= 1'b1;
                busy_cnt  <= 0;
            end else begin
                eng_error <= 1'b0;
                busy_cnt  <= eng_len;
            end
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign eng_busy = (busy_cnt != 0) || hold_busy;

    int   tests = 0;
    int   fails = 0;
    int   issued = 0;
    cmd_t exp_q[$];
    cmd_t mon_e;
    cmd_t last_c;
    bit   have_last = 1'b0;
    logic [CNT_W-1:0] exp_done = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every start pulse must match the next queued command; operands hold while busy.
    always @(negedge clk) begin
        if (rst) begin
            have_last = 1'b0;
        end else if (eng_start_fill || eng_start_blit) begin
            issued++;
            check("start_while_busy", eng_busy, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_start", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("issue_fill_pulse", eng_start_fill, mon_e.op == OP_FILL);
                check("issue_blit_pulse", eng_start_blit, mon_e.op == OP_BLIT);
                check("issue_operands",
                      {eng_x1, eng_y1, eng_x2, eng_y2, eng_fill_value, eng_blit_w, eng_blit_h},
                      {mon_e.x1, mon_e.y1, mon_e.x2, mon_e.y2, mon_e.fill_value, mon_e.blit_w, mon_e.blit_h});
                last_c    = mon_e;
                have_last = 1'b1;
            end
        end else if (eng_busy && have_last) begin
            check("operands_stable",
                  {eng_x1, eng_y1, eng_x2, eng_y2, eng_fill_value, eng_blit_w, eng_blit_h},
                  {last_c.x1, last_c.y1, last_c.x2, last_c.y2, last_c.fill_value, last_c.blit_w, last_c.blit_h});
        end
    end

    function automatic cmd_t mk(input logic op, input int x1, input int y1, input int x2,
                                input int y2, input logic v, input int w, input int h);
        cmd_t c;
        c.op = op;         c.x1 = X_W'(x1); c.y1 = Y_W'(y1); c.x2 = X_W'(x2);
        c.y2 = Y_W'(y2);   c.fill_value = v; c.blit_w = X_W'(w); c.blit_h = Y_W'(h);
        return c;
    endfunction

    // Returns at accept edge + 1 time unit.
    task automatic push_cmd(input cmd_t c);
        int t = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = c.op; cmd_x1 = c.x1; cmd_y1 = c.y1; cmd_x2 = c.x2;
        cmd_y2 = c.y2; cmd_fill_value = c.fill_value; cmd_blit_w = c.blit_w; cmd_blit_h = c.blit_h;
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            check("push_timeout", 0, 1);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            exp_q.push_back(c);
            #1 cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        @(posedge clk); #1;
        while (!idle && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        check(name, idle, 1);
    endtask

    initial begin
        int   n;
        int   snap;
        cmd_t c;

        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_queue_count", queue_count, 0);
        check("rst_done_count", done_count, 0);
        check("rst_err_sticky", err_sticky, 0);
        check("rst_idle", idle, 1);
        check("rst_starts", {eng_start_fill, eng_start_blit}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Single fill, engine busy 6 cycles
        eng_len = 6;
        push_cmd(mk(OP_FILL, 10, 5, 12, 6, 1'b1, 0, 0));
        check("t1_no_start_at_accept", eng_start_fill, 0);
        @(posedge clk); #1;
        check("t1_start_high", eng_start_fill, 1);
        check("t1_no_blit", eng_start_blit, 0);
        @(posedge clk); #1;
        check("t1_start_one_cycle", eng_start_fill, 0);
        wait_idle("t1_idle");
        exp_done = exp_done + 1'b1;
        check("t1_done_count", done_count, exp_done);
        check("t1_issued", issued, 1);

        // Five commands into a four-deep queue
        for (int i = 0; i < 4; i++)
            push_cmd(mk(1'(i % 2), 20 + i, 1, 30 + i, 2 + i, 1'(i % 2), 3 + i, 4));
        check("t2_ready_low_full", cmd_ready, 0);
        check("t2_count_full", queue_count, 4);
        push_cmd(mk(OP_BLIT, 40, 7, 50, 9, 1'b0, 11, 12));
        check("t2_fifth_after_first_done", done_count, exp_done + 1'b1);
        wait_idle("t2_idle");
        exp_done = exp_done + 8'd5;
        check("t2_done_count", done_count, exp_done);
        check("t2_issued", issued, 6);

        // Rejected blit followed by a good fill
        push_cmd(mk(OP_BLIT, 100, 0, 20, 10, 1'b0, 8, 4));
        push_cmd(mk(OP_FILL, 1, 1, 2, 2, 1'b0, 0, 0));
        wait_idle("t3_idle");
        check("t3_err_set", err_sticky, 1);
        exp_done = exp_done + 1'b1;
        check("t3_done_count", done_count, exp_done);
        check("t3_issued", issued, 8);
        @(negedge clk) err_clear = 1'b1;
        @(posedge clk); #1 err_clear = 1'b0;
        check("t3_err_cleared", err_sticky, 0);
        push_cmd(mk(OP_BLIT, 5, 9, 6, 3, 1'b1, 2, 2));
        @(posedge clk);
        @(posedge clk); #1 err_clear = 1'b1;
        @(posedge clk); #1 err_clear = 1'b0;
        check("t3_set_beats_clear", err_sticky, 1);
        wait_idle("t3b_idle");
        check("t3_done_unchanged", done_count, exp_done);

        // Push and pop in the same cycle at count 2
        eng_len = 0;
        push_cmd(mk(OP_FILL, 3, 3, 4, 4, 1'b1, 0, 0));
        push_cmd(mk(OP_BLIT, 6, 6, 7, 7, 1'b0, 5, 5));
        @(posedge clk); #1 hold_busy = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("t4_count_two", queue_count, 2);
        c = mk(OP_FILL, 8, 8, 9, 9, 1'b0, 0, 0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = c.op; cmd_x1 = c.x1; cmd_y1 = c.y1; cmd_x2 = c.x2;
        cmd_y2 = c.y2; cmd_fill_value = c.fill_value; cmd_blit_w = c.blit_w; cmd_blit_h = c.blit_h;
        hold_busy = 1'b0;
        @(posedge clk);
        exp_q.push_back(c);
        #1 cmd_valid = 1'b0;
        check("t4_count_stays_two", queue_count, 2);
        check("t4_pop_counted", done_count, exp_done + 1'b1);
        wait_idle("t4_idle");
        exp_done = exp_done + 8'd3;
        check("t4_done_count", done_count, exp_done);

        // done_count wrap
        n = 255 - int'(exp_done);
        for (int i = 0; i < n; i++)
            push_cmd(mk(1'(i % 2), i % 50, i % 40, 60, 50, 1'(i % 2), i % 30, i % 20));
        wait_idle("wrap_idle");
        check("wrap_at_255", done_count, 255);
        push_cmd(mk(OP_FILL, 0, 0, 0, 0, 1'b1, 0, 0));
        wait_idle("wrap_idle2");
        exp_done = '0;
        check("wrap_to_zero", done_count, 0);

        // Reset with the engine still running and commands queued
        eng_len = 40;
        push_cmd(mk(OP_FILL, 10, 10, 20, 20, 1'b1, 0, 0));
        push_cmd(mk(OP_BLIT, 11, 11, 21, 21, 1'b0, 4, 4));
        push_cmd(mk(OP_FILL, 12, 12, 22, 22, 1'b0, 0, 0));
        repeat (4) @(posedge clk);
        #1 check("rst_pre_count", queue_count, 3);
        @(negedge clk) rst = 1'b1;
        #1;
        check("rst_mid_count", queue_count, 0);
        check("rst_mid_ready", cmd_ready, 1);
        check("rst_mid_err", err_sticky, 0);
        check("rst_mid_done", done_count, 0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        exp_q.delete();
        snap = issued;
        push_cmd(mk(OP_BLIT, 30, 30, 40, 40, 1'b1, 7, 7));
        repeat (5) @(posedge clk);
        #1 check("rst_start_withheld", issued, snap);
        wait_idle("rst_idle");
        check("rst_new_issued", issued, snap + 1);
        check("rst_new_done", done_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
